// File: rtl/store_trace_fifo.sv
// Store trace FIFO: snoops CPU data-memory stores and drains {addr, data} pairs over valid/ready.
// Optional store match detector enabled by defining STORE_TRACE_MATCH_EN.
module store_trace_fifo #(
    parameter int             N          = 32,
    parameter int             DEPTH      = 8,
    parameter logic [N-1:0]   MATCH_ADDR = 32'd21,
    parameter logic [N-1:0]   MATCH_DATA = 32'h00000096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [N-1:0]             dataadr,
    input  logic [N-1:0]             writedata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_addr,
    output logic [N-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     match
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [N-1:0]   addr_mem_q [DEPTH];
    logic [N-1:0]   addr_mem_d [DEPTH];
    logic [N-1:0]   data_mem_q [DEPTH];
    logic [N-1:0]   data_mem_d [DEPTH];
    logic           overflow_q, overflow_d;
    logic [7:0]     drop_count_q, drop_count_d;

    logic           empty;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign pop  = !empty && out_ready;
    assign push = memwrite && (!full || pop);
    assign drop = memwrite && full && !pop;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        addr_mem_d   = addr_mem_q;
        data_mem_d   = data_mem_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) begin
            addr_mem_d[wr_idx] = dataadr;
            data_mem_d[wr_idx] = writedata;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: it is only observable through the pointers.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign out_valid  = !empty;
    assign out_addr   = empty ? '0 : addr_mem_q[rd_idx];
    assign out_data   = empty ? '0 : data_mem_q[rd_idx];
    assign count      = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

`ifdef STORE_TRACE_MATCH_EN
    logic match_q, match_d;

    // Dropped stores still count as seen by the detector.
    always_comb begin
        match_d = match_q;
        if (memwrite && (dataadr == MATCH_ADDR) && (writedata == MATCH_DATA)) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`else
    logic unused_match_cfg;
    assign unused_match_cfg = ^{MATCH_ADDR, MATCH_DATA};
    assign match            = 1'b0;
`endif

endmodule
